// File: rtl/alu_fn_exec_if.sv
// alu_fn_exec_if: request/response bundle for the alu_fn_exec execute unit.
//   master: drives in_valid, alu_fn, op_a, op_b, out_ready; observes in_ready and the result side.
//   slave : the execute unit; drives in_ready, out_valid, result, zero, illegal.
interface alu_fn_exec_if #(
  parameter int unsigned Width = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       alu_fn;
  logic [Width-1:0] op_a;
  logic [Width-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, alu_fn, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_fn, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_fn_exec.sv
// alu_fn_exec: multi-cycle EX-stage execute unit driven by the 6-bit ALUFn code.
//   clk_i   : rising-edge clock
//   reset_i : synchronous, active-high reset
//   bus_io  : alu_fn_exec_if.slave -- valid/ready request (alu_fn, op_a, op_b) and
//             valid/ready response (result, zero, illegal)
// Single-cycle ops finish one cycle after accept; shifts iterate one bit per cycle.
// Optional feature macro: ALU_FN_EXEC_MUL_EN enables a 32-cycle shift-add multiply
// (code 001100); without it that code is reported as illegal.
module alu_fn_exec (
  input logic           clk_i,
  input logic           reset_i,
  alu_fn_exec_if.slave  bus_io
);
  localparam int unsigned Width = 32;

  localparam logic [5:0] FnAdd = 6'b000000;
  localparam logic [5:0] FnSub = 6'b000001;
  localparam logic [5:0] FnAnd = 6'b000010;
  localparam logic [5:0] FnOr  = 6'b000100;
  localparam logic [5:0] FnXor = 6'b000110;
  localparam logic [5:0] FnSlt = 6'b001011;
  localparam logic [5:0] FnSll = 6'b001000;
  localparam logic [5:0] FnSrl = 6'b001001;
  localparam logic [5:0] FnSra = 6'b001010;
`ifdef ALU_FN_EXEC_MUL_EN
  localparam logic [5:0] FnMul = 6'b001100;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
`ifdef ALU_FN_EXEC_MUL_EN
    , StMul
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       fn_q, fn_d;
  logic [Width-1:0] sh_q, sh_d;     // shift register; product accumulator in StMul
  logic [5:0]       cnt_q, cnt_d;   // remaining iterations
  logic [Width-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic [Width-1:0] sh_next;
`ifdef ALU_FN_EXEC_MUL_EN
  logic [Width-1:0] mcand_q, mcand_d;
  logic [Width-1:0] mplier_q, mplier_d;
`endif

  always_comb begin
    state_d   = state_q;
    fn_d      = fn_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    sh_next   = sh_q;
`ifdef ALU_FN_EXEC_MUL_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          fn_d      = bus_io.alu_fn;
          illegal_d = 1'b0;
          state_d   = StDone;
          unique case (bus_io.alu_fn)
            FnAdd: result_d = bus_io.op_a + bus_io.op_b;
            FnSub: result_d = bus_io.op_a - bus_io.op_b;
            FnAnd: result_d = bus_io.op_a & bus_io.op_b;
            FnOr:  result_d = bus_io.op_a | bus_io.op_b;
            FnXor: result_d = bus_io.op_a ^ bus_io.op_b;
            FnSlt: result_d = ($signed(bus_io.op_a) < $signed(bus_io.op_b)) ? 32'd1 : 32'd0;
            FnSll, FnSrl, FnSra: begin
              sh_d  = bus_io.op_a;
              cnt_d = {1'b0, bus_io.op_b[4:0]};
              if (bus_io.op_b[4:0] != 5'd0) begin
                state_d = StShift;
              end else begin
                result_d = bus_io.op_a;
              end
            end
`ifdef ALU_FN_EXEC_MUL_EN
            FnMul: begin
              sh_d     = '0;
              mcand_d  = bus_io.op_a;
              mplier_d = bus_io.op_b;
              cnt_d    = 6'd32;
              state_d  = StMul;
            end
`endif
            default: begin
              result_d  = '0;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      StShift: begin
        unique case (fn_q)
          FnSrl:   sh_next = sh_q >> 1;
          FnSra:   sh_next = $signed(sh_q) >>> 1;
          default: sh_next = sh_q << 1;
        endcase
        sh_d  = sh_next;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          result_d = sh_next;
          state_d  = StDone;
        end
      end
`ifdef ALU_FN_EXEC_MUL_EN
      StMul: begin
        sh_next  = mplier_q[0] ? (sh_q + mcand_q) : sh_q;
        sh_d     = sh_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          result_d = sh_next;
          state_d  = StDone;
        end
      end
`endif
      StDone: begin
        if (bus_io.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // result only changes on entry to StDone, so zero tracks it without extra gating
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      fn_q      <= '0;
      sh_q      <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
`ifdef ALU_FN_EXEC_MUL_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      fn_q      <= fn_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifdef ALU_FN_EXEC_MUL_EN
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
`endif
    end
  end

  assign bus_io.in_ready  = (state_q == StIdle);
  assign bus_io.out_valid = (state_q == StDone);
  assign bus_io.result    = result_q;
  assign bus_io.zero      = zero_q;
  assign bus_io.illegal   = illegal_q;

endmodule
